xc_aesmix: RTL and testbench



---
 rtl/xc_aesmix.sv | 119 +++++++++++
 tb/tb_xc_aesmix.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns unit: one output byte per cycle over GF(2^8) mod 0x11B.
// Optional output byte rotation enabled by defining XC_AESMIX_ROT_EN (adds the rot port).
module xc_aesmix #(
  parameter logic [31:0] RESULT_RESET = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_data,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
`ifdef XC_AESMIX_ROT_EN
  input  logic        rot,
`endif
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_wr;
  logic [1:0]  w_idx;
  logic [31:0] r_result;
  logic [7:0]  w_col [4];
  logic [7:0]  w_a   [4];
  logic [7:0]  w_x2  [4];
  logic [7:0]  w_x4  [4];
  logic [7:0]  w_x8  [4];
  logic [7:0]  w_fwd;
  logic [7:0]  w_inv;
  logic [7:0]  w_byte;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Output byte index equals the state position in the S0..S3 sequence.
  always_comb begin
    w_idx = 2'd0;
    unique case (r_state)
      StS1:    w_idx = 2'd1;
      StS2:    w_idx = 2'd2;
      StS3:    w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_col[0] = rs1[7:0];
    w_col[1] = rs2[15:8];
    w_col[2] = rs1[23:16];
    w_col[3] = rs2[31:24];
    for (int k = 0; k < 4; k++) begin
      w_a[k]  = w_col[w_idx + 2'(k)];
      w_x2[k] = xtime(w_a[k]);
      w_x4[k] = xtime(w_x2[k]);
      w_x8[k] = xtime(w_x4[k]);
    end
    w_fwd  = w_x2[0] ^ (w_x2[1] ^ w_a[1]) ^ w_a[2] ^ w_a[3];
    w_inv  = (w_x8[0] ^ w_x4[0] ^ w_x2[0]) ^ (w_x8[1] ^ w_x2[1] ^ w_a[1])
           ^ (w_x8[2] ^ w_x4[2] ^ w_a[2]) ^ (w_x8[3] ^ w_a[3]);
    w_byte = enc ? w_fwd : w_inv;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    if (flush) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (valid) begin
          w_wr        = 1'b1;
          w_state_nxt = StS1;
        end
        StS1: begin
          w_wr        = valid;
          w_state_nxt = valid ? StS2 : StIdle;
        end
        StS2: begin
          w_wr        = valid;
          w_state_nxt = valid ? StS3 : StIdle;
        end
        StS3: begin
          w_wr        = valid;
          w_state_nxt = valid ? StDone : StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_result <= RESULT_RESET;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_result <= flush_data;
      end else if (w_wr) begin
        r_result[{w_idx, 3'b000} +: 8] <= w_byte;
      end
    end
  end

  assign ready = (r_state == StDone);

`ifdef XC_AESMIX_ROT_EN
  assign result = rot ? {r_result[23:0], r_result[31:24]} : r_result;
`else
  assign result = r_result;
`endif

endmodule

// File: tb/tb_xc_aesmix.sv
// Self-checking bench for xc_aesmix: spec vectors, control corner cases, random vs GF model.
module tb_xc_aesmix;

  logic        clock = 1'b0;
  logic        reset, flush, valid, enc, ready;
  logic [31:0] flush_data, rs1, rs2, result;
`ifdef XC_AESMIX_ROT_EN
  logic        rot;
`endif

  int tests = 0;
  int fails = 0;

  xc_aesmix dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_data (flush_data),
    .valid      (valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .enc        (enc),
`ifdef XC_AESMIX_ROT_EN
    .rot        (rot),
`endif
    .ready      (ready),
    .result     (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        enc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  // Plain shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model(input logic e, input logic [31:0] r1, input logic [31:0] r2);
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [31:0] out = 32'h0;
    a[0] = r1[7:0]; a[1] = r2[15:8]; a[2] = r1[23:16]; a[3] = r2[31:24];
    if (e) begin c[0] = 8'd2; c[1] = 8'd3; c[2] = 8'd1; c[3] = 8'd1; end
    else begin c[0] = 8'd14; c[1] = 8'd11; c[2] = 8'd13; c[3] = 8'd9; end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b = 8'h00;
      for (int j = 0; j < 4; j++) b ^= gmul(c[j], a[(i + j) % 4]);
      out[8*i +: 8] = b;
    end
    return out;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count cycles with ready high over n cycles, valid low.
  task automatic expect_quiet(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ready) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic run_op(input string name, input logic e, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold_extra);
    int  n = 0;
    bit  got = 0;
    enc = e; rs1 = a; rs2 = b; valid = 1'b1;
    while (!got && n < 12) begin
      tick();
      n++;
      if (ready) got = 1;
    end
    check({name, " latency"}, 32'(n), 32'd4);
    if (got) check({name, " result"}, result, exp);
    if (hold_extra) tick();
    valid = 1'b0;
    tick();
    check({name, " ready drops"}, 32'(ready), 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    logic [31:0] hold;
    vecs[0] = '{"fwd", 1'b1, 32'h005300DB, 32'h45001300, 32'hBCA14D8E};
    vecs[1] = '{"inv", 1'b0, 32'h00A1008E, 32'hBC004D00, 32'h455313DB};
    vecs[2] = '{"c6", 1'b1, 32'hC6C6C6C6, 32'hC6C6C6C6, 32'hC6C6C6C6};
    vecs[3] = '{"d4d5", 1'b1, 32'h00D400D4, 32'hD500D400, 32'hD6D7D5D5};

    reset = 1'b1; flush = 1'b0; flush_data = 32'h0; valid = 1'b0; enc = 1'b0;
    rs1 = 32'h0; rs2 = 32'h0;
`ifdef XC_AESMIX_ROT_EN
    rot = 1'b0;
`endif
    #12;
    check("reset ready", 32'(ready), 32'd0);
    check("reset result", result, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].enc, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, 0);

    // Flush during S2: no ready, flush_data loaded, next op normal.
    enc = 1'b1; rs1 = 32'h005300DB; rs2 = 32'h45001300; valid = 1'b1;
    tick(); tick();
    flush = 1'b1; flush_data = 32'hCAFEF00D; valid = 1'b0;
    tick();
    flush = 1'b0;
    check("flush ready", 32'(ready), 32'd0);
    check("flush result", result, 32'hCAFEF00D);
    expect_quiet("flush no ready", 6);
    run_op("after flush", 1'b1, 32'h005300DB, 32'h45001300, 32'hBCA14D8E, 0);

    // Asynchronous reset between edges while in S3.
    enc = 1'b1; rs1 = 32'h005300DB; rs2 = 32'h45001300; valid = 1'b1;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("async reset ready", 32'(ready), 32'd0);
    check("async reset result", result, 32'h0);
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    expect_quiet("after reset no ready", 6);
    check("after reset result held", result, 32'h0);
    run_op("after reset", 1'b0, 32'h00A1008E, 32'hBC004D00, 32'h455313DB, 0);

    // Valid dropped in S1: abort silently.
    enc = 1'b1; rs1 = 32'h005300DB; rs2 = 32'h45001300; valid = 1'b1;
    tick();
    valid = 1'b0;
    expect_quiet("valid drop no ready", 8);

    // Valid held across the DONE cycle: no second ready until re-asserted.
    run_op("hold extra", 1'b1, 32'hC6C6C6C6, 32'hC6C6C6C6, 32'hC6C6C6C6, 1);
    expect_quiet("hold extra no 2nd ready", 6);
    run_op("reassert", 1'b1, 32'h00D400D4, 32'hD500D400, 32'hD6D7D5D5, 0);

`ifdef XC_AESMIX_ROT_EN
    rot = 1'b1;
    run_op("rot1", 1'b1, 32'h005300DB, 32'h45001300, 32'hA14D8EBC, 0);
    rot = 1'b0;
    check("rot0 same register", result, 32'hBCA14D8E);
`endif

    for (int i = 0; i < 24; i++) begin
      logic        e = 1'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      hold = model(e, a, b);
`ifdef XC_AESMIX_ROT_EN
      rot = 1'($urandom);
      if (rot) hold = {hold[23:0], hold[31:24]};
`endif
      run_op("random", e, a, b, hold, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
